// File: rtl/mmss_counter_pkg.sv
// mmss_counter_pkg: shared state encoding, field width and helpers for mmss_counter
//   W           : width of the min/sec fields (matches split_digits in[5:0])
//   MAX_VAL_DEF : default terminal value of both fields
//   state_e     : ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2 bits)
//   sat()       : clamps a preload value to the terminal value
package mmss_counter_pkg;

    localparam int W           = 6;
    localparam int MAX_VAL_DEF = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [W-1:0] sat(input logic [W-1:0] v, input logic [W-1:0] m);
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/mmss_counter_tick_gen.sv
// mmss_counter_tick_gen: prescaler producing one step pulse every TICK_DIV enabled cycles
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   en_i   : count enable (high while running)
//   zero_i : restart the prescaler from 0 (wins over en_i)
//   tick_o : high in the cycle the prescaler sits at TICK_DIV-1 while enabled
module mmss_counter_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic zero_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb cnt_d = zero_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mmss_counter.sv
// mmss_counter: minutes:seconds counter with run/pause/clear/load control
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset
//   start_i      : pulse, begin/resume counting
//   stop_i       : pulse, pause counting (wins over start_i)
//   clear_i      : pulse, zero the counts and return to idle (highest priority)
//   load_i       : pulse, preload load_min_i/load_sec_i when idle or paused
//   load_min_i   : minutes preload, saturated to MAX_VAL
//   load_sec_i   : seconds preload, saturated to MAX_VAL
//   dir_i        : 0 up, 1 down (only when MMSS_COUNTDOWN_EN is defined)
//   min_o, sec_o : binary counts 0..MAX_VAL
//   tick_o       : one-cycle pulse on each count step
//   running_o    : high while running
//   rollover_o   : one-cycle pulse together with the MAX:MAX -> 00:00 update
//   done_o       : high once a countdown reached 00:00
// Build option: define MMSS_COUNTDOWN_EN to enable down counting and the done state.
module mmss_counter
    import mmss_counter_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_VAL  = MAX_VAL_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_min_i,
    input  logic [W-1:0] load_sec_i,
    input  logic         dir_i,
    output logic [W-1:0] min_o,
    output logic [W-1:0] sec_o,
    output logic         tick_o,
    output logic         running_o,
    output logic         rollover_o,
    output logic         done_o
);

    localparam logic [W-1:0] MAXV = W'(MAX_VAL);

    state_e       state_q, state_d;
    logic [W-1:0] min_q, min_d, sec_q, sec_d;
    logic         roll_q, roll_d;
    logic         load_ok, go, en, zero, down, hit_zero, wrap;

`ifdef MMSS_COUNTDOWN_EN
    assign down = dir_i;
`else
    logic unused_dir;
    assign down       = 1'b0;
    assign unused_dir = dir_i;
`endif

    // A same-cycle load beats stop/start; stop beats start.
    always_comb begin
        load_ok  = load_i && !clear_i && (state_q == ST_IDLE || state_q == ST_PAUSE);
        go       = start_i && !stop_i && !clear_i && !load_ok;
        en       = rst_ni && !clear_i && (state_q == ST_RUN);
        zero     = clear_i || load_ok || (state_q == ST_IDLE && go);
        hit_zero = down && (min_q == '0) && (sec_q <= W'(1));
        wrap     = !down && (min_q == MAXV) && (sec_q == MAXV);
    end

    mmss_counter_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en),
        .zero_i (zero),
        .tick_o (tick_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Reaching 00:00 on a down step wins over a simultaneous stop.
    always_comb begin
        state_d = state_q;
        if (clear_i)                           state_d = ST_IDLE;
        else if (state_q == ST_RUN)            state_d = (tick_o && hit_zero) ? ST_DONE : stop_i ? ST_PAUSE : ST_RUN;
        else if (go && state_q != ST_DONE)     state_d = ST_RUN;
    end

    always_comb begin
        running_o = (state_q == ST_RUN);
`ifdef MMSS_COUNTDOWN_EN
        done_o    = (state_q == ST_DONE);
`else
        done_o    = 1'b0;
`endif
    end

    always_comb begin
        min_d  = min_q;
        sec_d  = sec_q;
        roll_d = 1'b0;
        if (clear_i) begin
            min_d = '0;
            sec_d = '0;
        end else if (load_ok) begin
            min_d = sat(load_min_i, MAXV);
            sec_d = sat(load_sec_i, MAXV);
        end else if (tick_o && down) begin
            min_d = hit_zero ? '0 : (sec_q == '0) ? min_q - 1'b1 : min_q;
            sec_d = hit_zero ? '0 : (sec_q == '0) ? MAXV : sec_q - 1'b1;
        end else if (tick_o) begin
            roll_d = wrap;
            sec_d  = (sec_q == MAXV) ? '0 : sec_q + 1'b1;
            min_d  = (sec_q != MAXV) ? min_q : (min_q == MAXV) ? '0 : min_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            min_q  <= '0;
            sec_q  <= '0;
            roll_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            sec_q  <= sec_d;
            roll_q <= roll_d;
        end
    end

    assign min_o      = min_q;
    assign sec_o      = sec_q;
    assign rollover_o = roll_q;

endmodule

// File: tb/tb_mmss_counter.sv
// tb_mmss_counter: directed plus random stimulus against a total-seconds reference model
module tb_mmss_counter;

    localparam int TD = 4;
    localparam int MX = 59;
    localparam int TOP = (MX + 1) * (MX + 1) - 1;
`ifdef MMSS_COUNTDOWN_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
    logic [5:0] lmin = '0, lsec = '0;
    logic [5:0] min_o, sec_o;
    logic       tick_o, running_o, rollover_o, done_o;

    always #5 clk = ~clk;

    mmss_counter #(.TICK_DIV(TD), .MAX_VAL(MX)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .stop_i     (stop),
        .clear_i    (clear),
        .load_i     (load),
        .load_min_i (lmin),
        .load_sec_i (lsec),
        .dir_i      (dir),
        .min_o      (min_o),
        .sec_o      (sec_o),
        .tick_o     (tick_o),
        .running_o  (running_o),
        .rollover_o (rollover_o),
        .done_o     (done_o)
    );

    int checks = 0, errors = 0;
    int m_mode = M_IDLE, m_t = 0, m_ph = 0;
    bit m_roll = 1'b0;
    bit saw_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model state: total elapsed seconds m_t, prescaler phase m_ph, mode m_mode.
    task automatic model_edge();
        int  old;
        bit  tk;
        if (!rst_n) begin
            m_mode = M_IDLE; m_t = 0; m_ph = 0; m_roll = 0;
            return;
        end
        m_roll = 0;
        old    = m_mode;
        if (clear) begin
            m_mode = M_IDLE; m_t = 0; m_ph = 0;
        end else if (load && (old == M_IDLE || old == M_PAUSE)) begin
            m_t  = (lmin > MX ? MX : int'(lmin)) * (MX + 1) + (lsec > MX ? MX : int'(lsec));
            m_ph = 0;
        end else begin
            tk = (old == M_RUN) && (m_ph == TD - 1);
            if (old == M_RUN) m_ph = tk ? 0 : m_ph + 1;
            if (tk) begin
                if (CD && dir) begin
                    if (m_t <= 1) begin m_t = 0; m_mode = M_DONE; end
                    else m_t--;
                end else if (m_t == TOP) begin
                    m_t = 0; m_roll = 1;
                end else m_t++;
            end
            if (m_mode == M_RUN && stop) m_mode = M_PAUSE;
            else if ((old == M_IDLE || old == M_PAUSE) && start && !stop) begin
                if (old == M_IDLE) m_ph = 0;
                m_mode = M_RUN;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("tick", tick_o, rst_n && m_mode == M_RUN && m_ph == TD - 1 && !clear);
        saw_tick = tick_o;
        @(posedge clk);
        model_edge();
        #1;
        chk("min", min_o, m_t / (MX + 1));
        chk("sec", sec_o, m_t % (MX + 1));
        chk("running", running_o, m_mode == M_RUN);
        chk("done", done_o, m_mode == M_DONE);
        chk("rollover", rollover_o, m_roll);
        start = 0; stop = 0; clear = 0; load = 0; rst_n = 1;
    endtask

    initial begin
        int n, last, r;
        // reset
        rst_n = 0; cycle(); rst_n = 0; cycle();
        chk("rst_min", min_o, 0);
        chk("rst_sec", sec_o, 0);
        chk("rst_running", running_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_done", done_o, 0);
        // 40 cycles of counting up
        start = 1; cycle();
        n = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (saw_tick) begin
                n++;
                if (last >= 0) chk("tick_gap", i - last, TD);
                last = i;
            end
        end
        chk("tick_count", n, 10);
        chk("run_sec", sec_o, 10);
        chk("run_min", min_o, 0);
        // wrap from 59:58
        clear = 1; cycle();
        load = 1; lmin = 59; lsec = 58; cycle();
        start = 1; cycle();
        repeat (4) cycle();
        chk("pre_wrap_min", min_o, 59);
        chk("pre_wrap_sec", sec_o, 59);
        repeat (4) cycle();
        chk("wrap_min", min_o, 0);
        chk("wrap_sec", sec_o, 0);
        chk("wrap_roll", rollover_o, 1);
        // pause/resume and load rules
        clear = 1; cycle();
        load = 1; lmin = 0; lsec = 4; cycle();
        start = 1; cycle();
        repeat (3) cycle();
        stop = 1; start = 1; cycle();
        chk("pause_sec", sec_o, 5);
        chk("pause_running", running_o, 0);
        repeat (3) cycle();
        chk("pause_hold", sec_o, 5);
        start = 1; cycle();
        repeat (3) cycle();
        chk("resume_wait", sec_o, 5);
        cycle();
        chk("resume_step", sec_o, 6);
        load = 1; lmin = 30; lsec = 30; cycle();
        chk("run_load_ignored", min_o, 0);
        stop = 1; cycle();
        load = 1; lmin = 2; lsec = 63; cycle();
        chk("sat_sec", sec_o, 59);
        chk("sat_min", min_o, 2);
        // clear and reset mid-run
        start = 1; cycle();
        repeat (6) cycle();
        clear = 1; cycle();
        chk("clear_sec", sec_o, 0);
        chk("clear_min", min_o, 0);
        chk("clear_running", running_o, 0);
        start = 1; cycle();
        repeat (9) cycle();
        rst_n = 0; cycle();
        chk("midrst_sec", sec_o, 0);
        chk("midrst_running", running_o, 0);
`ifdef MMSS_COUNTDOWN_EN
        dir = 1; load = 1; lmin = 1; lsec = 0; cycle();
        start = 1; cycle();
        repeat (4) cycle();
        chk("cd_first_min", min_o, 0);
        chk("cd_first_sec", sec_o, 59);
        repeat (236) cycle();
        chk("cd_done", done_o, 1);
        chk("cd_running", running_o, 0);
        chk("cd_sec", sec_o, 0);
        start = 1; cycle();
        repeat (8) cycle();
        chk("cd_frozen_done", done_o, 1);
        chk("cd_frozen_running", running_o, 0);
        chk("cd_frozen_min", min_o, 0);
        clear = 1; cycle();
        chk("cd_clear_done", done_o, 0);
        dir = 0;
`else
        dir = 1; start = 1; cycle();
        repeat (4) cycle();
        chk("dir_ignored_sec", sec_o, 1);
        chk("dir_ignored_done", done_o, 0);
        dir = 0; clear = 1; cycle();
`endif
        // random control traffic
        repeat (600) begin
            r     = $urandom_range(0, 99);
            start = (r < 10);
            stop  = (r >= 10 && r < 13);
            clear = (r == 13);
            load  = (r >= 14 && r < 18);
            rst_n = !(r == 18);
            if (r >= 19 && r < 21) begin start = 1; stop = 1; end
            lmin  = 6'($urandom_range(50, 63));
            lsec  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
